// File: rtl/viterbi_dec_if.sv
// Request/result bundle for viterbi_dec. The optional err_cnt field (and the
// MW parameter that sizes it) exist only when VITERBI_ERRCNT_EN is defined.
interface viterbi_dec_if #(
   parameter int BITS = 48
`ifdef VITERBI_ERRCNT_EN
   , parameter int MW = 8
`endif
);
   // start is a single-cycle request, taken only while the decoder is idle or
   // done; busy/done are levels and dec_out is valid whenever done is high.
   logic                start;
   logic [2*BITS-1:0]   in_code;
   logic [BITS-1:0]     dec_out;
   logic                busy;
   logic                done;
   logic [1:0]          dbg_state;
`ifdef VITERBI_ERRCNT_EN
   logic [MW-1:0]       err_cnt;
`endif

   modport master (
      output start, in_code,
      input  dec_out, busy, done, dbg_state
`ifdef VITERBI_ERRCNT_EN
      , input err_cnt
`endif
   );

   modport slave (
      input  start, in_code,
      output dec_out, busy, done, dbg_state
`ifdef VITERBI_ERRCNT_EN
      , output err_cnt
`endif
   );
endinterface

// File: rtl/viterbi_dec.sv
// Block Viterbi decoder, rate 1/2, K=4 (8 states), no tail bits: BITS ACS steps
// then BITS traceback steps. Define VITERBI_ERRCNT_EN to add the err_cnt output.
module viterbi_dec #(
   parameter int BITS = 48,
   parameter int MW   = 8
) (
   input  logic          clk,
   input  logic          rst,
   viterbi_dec_if.slave  bus
);
   localparam int CW = $clog2(BITS);

   typedef enum logic [1:0] {S_IDLE, S_ACS, S_TB, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [2*BITS-1:0]   code_q;
   logic [MW-1:0]       met_q [8];
   logic [CW-1:0]       step_q;
   logic [7:0]          surv_q [BITS];
   logic [BITS-1:0]     dec_reg, dec_q;
   logic [2:0]          tb_state_q;
   logic                tb_end_q;
   logic                busy_q, done_q;
   logic                accept, last_step;

   logic [1:0]          sym;
   logic [MW-1:0]       sum_a [8];
   logic [MW-1:0]       sum_b [8];
   logic [MW-1:0]       met_d [8];
   logic [7:0]          dec_d;
   logic [MW-1:0]       best_met;
   logic [2:0]          best_idx;

   // Hamming distance between received symbol y={p1,p0} and the branch
   // leaving predecessor s with input bit u.
   function automatic logic [1:0] branch_metric(input logic [2:0] s, input logic u,
                                                input logic [1:0] y);
      logic p1, p0;
      p1 = u ^ s[1] ^ s[0];
      p0 = u ^ s[2] ^ s[1] ^ s[0];
      return {1'b0, p1 ^ y[1]} + {1'b0, p0 ^ y[0]};
   endfunction

   assign sym       = code_q[(2*BITS-1) - 2*int'(step_q) -: 2];
   assign last_step = (step_q == CW'(BITS-1));
   assign accept    = ((state_q == S_IDLE) || (state_q == S_DONE)) && bus.start;

   // Next state n={u,a,b} is reached from {a,b,0} or {a,b,1}; the first wins ties.
   always_comb begin
      for (int n = 0; n < 8; n++) begin
         sum_a[n] = met_q[3'((2*n) % 8)]
                    + MW'(branch_metric(3'((2*n) % 8), n[2], sym));
         sum_b[n] = met_q[3'((2*n + 1) % 8)]
                    + MW'(branch_metric(3'((2*n + 1) % 8), n[2], sym));
         dec_d[n] = (sum_b[n] < sum_a[n]);
         met_d[n] = dec_d[n] ? sum_b[n] : sum_a[n];
      end
      best_met = met_d[0];
      best_idx = 3'd0;
      for (int n = 1; n < 8; n++) begin
         if (met_d[n] < best_met) begin
            best_met = met_d[n];
            best_idx = 3'(n);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: if (bus.start) state_d = S_ACS;
         S_ACS:          if (last_step) state_d = S_TB;
         S_TB:           if (tb_end_q)  state_d = S_DONE;
         default:        state_d = S_IDLE;
      endcase
   end

`ifdef VITERBI_ERRCNT_EN
   logic [MW-1:0] best_q, err_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         code_q     <= '0;
         step_q     <= '0;
         dec_reg    <= '0;
         dec_q      <= '0;
         tb_state_q <= '0;
         tb_end_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         for (int i = 0; i < 8; i++) met_q[i] <= '0;
`ifdef VITERBI_ERRCNT_EN
         best_q     <= '0;
         err_q      <= '0;
`endif
      end else begin
         state_q <= state_d;
         if (accept) begin
            code_q   <= bus.in_code;
            step_q   <= '0;
            tb_end_q <= 1'b0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            for (int i = 0; i < 8; i++) met_q[i] <= (i == 0) ? '0 : MW'(128);
         end else if (state_q == S_ACS) begin
            for (int i = 0; i < 8; i++) met_q[i] <= met_d[i];
            if (last_step) begin
               tb_state_q <= best_idx;
`ifdef VITERBI_ERRCNT_EN
               best_q     <= best_met;
`endif
            end else begin
               step_q <= step_q + 1'b1;
            end
         end else if (state_q == S_TB) begin
            // One extra TB cycle after step 0 so the final bit is registered
            // before dec_out is published.
            if (tb_end_q) begin
               dec_q  <= dec_reg;
               done_q <= 1'b1;
               busy_q <= 1'b0;
`ifdef VITERBI_ERRCNT_EN
               err_q  <= best_q;
`endif
            end else begin
               dec_reg[(BITS-1) - int'(step_q)] <= tb_state_q[2];
               tb_state_q <= {tb_state_q[1:0], surv_q[step_q][tb_state_q]};
               if (step_q == '0) tb_end_q <= 1'b1;
               else              step_q   <= step_q - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == S_ACS) surv_q[step_q] <= dec_d;
   end

   assign bus.dec_out   = dec_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.dbg_state = state_q;
`ifdef VITERBI_ERRCNT_EN
   assign bus.err_cnt   = err_q;
`endif
endmodule

// File: tb/tb_viterbi_dec.sv
// Directed bench for viterbi_dec: hand-derived code blocks and expected
// results, latency/handshake checks, ignored restarts and mid-decode reset.
module tb_viterbi_dec;
   localparam int BITS = 48;
   localparam int MW   = 8;

   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_pass   = 0;
   logic [BITS-1:0] exp_q [$];
   logic [BITS-1:0] last_dec;

   viterbi_dec_if #(
      .BITS(BITS)
`ifdef VITERBI_ERRCNT_EN
      , .MW(MW)
`endif
   ) vif ();

   viterbi_dec #(.BITS(BITS), .MW(MW)) dut (.clk(clk), .rst(rst), .bus(vif));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [2*BITS-1:0] encode(input logic [BITS-1:0] u);
      logic [2*BITS-1:0] c;
      logic [2:0] s;
      logic b;
      c = '0;
      s = 3'b000;
      for (int j = 0; j < BITS; j++) begin
         b = u[BITS-1-j];
         c[2*BITS-1-2*j]   = b ^ s[1] ^ s[0];
         c[2*BITS-2-2*j]   = b ^ s[2] ^ s[1] ^ s[0];
         s = {b, s[2:1]};
      end
      return c;
   endfunction

   // Accept edge becomes edge 0; returns at edge 0 + 1ns.
   task automatic launch(input logic [2*BITS-1:0] code, input logic [BITS-1:0] exp,
                         input string tag);
      @(negedge clk);
      vif.in_code = code;
      vif.start   = 1'b1;
      @(posedge clk);
      #1;
      vif.start = 1'b0;
      exp_q.push_back(exp);
      check({tag, "_busy0"}, 64'(vif.busy), 64'd1);
      check({tag, "_done0"}, 64'(vif.done), 64'd0);
      check({tag, "_state0"}, 64'(vif.dbg_state), 64'd1);
   endtask

   // Caller is at edge e + 1ns; left = 97 - e.
   task automatic expect_done(input int left, input logic [MW-1:0] err, input string tag);
      logic [BITS-1:0] exp;
      repeat (left - 1) @(posedge clk);
      #1;
      check({tag, "_early_done"}, 64'(vif.done), 64'd0);
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      check({tag, "_done"}, 64'(vif.done), 64'd1);
      check({tag, "_busy"}, 64'(vif.busy), 64'd0);
      check({tag, "_dec"}, 64'(vif.dec_out), 64'(exp));
`ifdef VITERBI_ERRCNT_EN
      check({tag, "_err"}, 64'(vif.err_cnt), 64'(err));
`else
      if (err > MW'(0)) ; // error count not observable in this build
`endif
      last_dec = exp;
   endtask

   initial begin
      logic [2*BITS-1:0] code;
      logic [BITS-1:0]   u;

      rst         = 1'b1;
      vif.start   = 1'b0;
      vif.in_code = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(vif.busy), 64'd0);
      check("rst_done", 64'(vif.done), 64'd0);
      check("rst_dec", 64'(vif.dec_out), 64'd0);
      check("rst_state", 64'(vif.dbg_state), 64'd0);
`ifdef VITERBI_ERRCNT_EN
      check("rst_err", 64'(vif.err_cnt), 64'd0);
`endif
      @(negedge clk);
      rst = 1'b0;

      launch('0, '0, "zero");
      expect_done(97, 8'd0, "zero");
      check("zero_state", 64'(vif.dbg_state), 64'd3);

      code = '0;
      code[95:88] = 8'hDF;
      launch(code, 48'h8000_0000_0000, "u0");
      expect_done(97, 8'd0, "u0");

      code[95:88] = 8'h5F;
      launch(code, 48'h8000_0000_0000, "u0_err1");
      expect_done(97, 8'd1, "u0_err1");

      u = 48'hA5A5_C3C3_0F0F;
      code = encode(u);
      code[80] = ~code[80];
      code[40] = ~code[40];
      launch(code, u, "a5_err2");
      expect_done(97, 8'd2, "a5_err2");

      // Back-to-back: this launch drives start in the cycle done rose.
      launch(encode(48'hFFFF_FFFF_FFFF), 48'hFFFF_FFFF_FFFF, "ones");
      expect_done(97, 8'd0, "ones");

      launch(encode(48'h0000_0000_0001), 48'h0000_0000_0001, "last_bit");
      expect_done(97, 8'd0, "last_bit");

      // A second start at edge 30 must be ignored.
      u = 48'h1234_5678_9ABC;
      launch(encode(u), u, "ign");
      repeat (29) @(posedge clk);
      @(negedge clk);
      vif.in_code = encode(48'hFEDC_BA98_7654);
      vif.start   = 1'b1;
      @(posedge clk);
      #1;
      vif.start = 1'b0;
      check("ign_busy30", 64'(vif.busy), 64'd1);
      check("ign_hold30", 64'(vif.dec_out), 64'(last_dec));
      expect_done(67, 8'd0, "ign");

      // Reset at edge 60 aborts the decode with no dec_out update.
      launch(encode(48'hDEAD_BEEF_0001), 48'hDEAD_BEEF_0001, "abort");
      repeat (60) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("abort_busy", 64'(vif.busy), 64'd0);
      check("abort_done", 64'(vif.done), 64'd0);
      check("abort_dec", 64'(vif.dec_out), 64'd0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      u = 48'h0F0F_3C3C_5A5A;
      code = encode(u);
      code[3] = ~code[3];
      launch(code, u, "fresh");
      expect_done(97, 8'd1, "fresh");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/viterbi_dec.md
VITERBI_DEC -- requirements
Module: viterbi_dec

Interface
REQ-001 SHALL have parameter BITS, default 48: the number of information bits per block.
REQ-002 SHALL have parameter MW, default 8: the path-metric width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the posedge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: a one-cycle request to decode in_code.
REQ-006 SHALL have port in_code, input, 2*BITS bits: the rate-1/2 code block; symbol j is {p1,p0} at in_code[2*BITS-1-2j -: 2].
REQ-007 SHALL have port dec_out, output, BITS bits: the decoded information bits; dec_out[BITS-1-j] = u[j].
REQ-008 SHALL have port busy, output, 1 bit: high while a decode is in progress.
REQ-009 SHALL have port done, output, 1 bit: level; high once dec_out is valid, held until the next accepted start.

Function
REQ-010 SHALL decode the code in which symbol j has p0 = u[j]^u[j-1]^u[j-2]^u[j-3] and p1 = u[j]^u[j-2]^u[j-3], with u[k<0] = 0 and no tail bits.
REQ-011 SHALL use 8 trellis states; state index = {u[j-1],u[j-2],u[j-3]}, MSB first.
REQ-012 SHALL implement states IDLE, ACS, TB and DONE; DONE accepts start exactly as IDLE does.
REQ-013 SHALL latch in_code and enter ACS on a posedge with start=1 in IDLE or DONE; the same edge sets busy=1 and done=0.
REQ-014 SHALL ignore start in ACS and TB; the latched code is unchanged.
REQ-015 SHALL, on entry to ACS, initialise the state-0 metric to 0 and every other metric to 128.
REQ-016 SHALL process one trellis step per cycle for all 8 states in parallel during ACS: 2-bit Hamming branch metric, add, compare, select; BITS cycles total.
REQ-017 SHALL, when two predecessor sums are equal, select the predecessor with the lower state index.
REQ-018 SHALL store one survivor decision bit per state per step (8 x BITS bits).
REQ-019 SHALL, in the last ACS cycle, choose the final state as the minimum metric, with the lowest index winning ties.
REQ-020 SHALL run traceback for BITS cycles, from step BITS-1 down to 0, writing one decoded bit into an internal register per cycle.
REQ-021 SHALL update dec_out only on the TB-to-DONE edge; dec_out holds its old value during ACS and TB.
REQ-022 SHALL give latency as: accepted start at edge 0 -> done=1 and busy=0 at edge 2*BITS+1 (97 for BITS=48).
REQ-023 SHALL never let metrics wrap with MW=8: the maximum is 128+2*BITS = 224; no normalisation is needed.
REQ-024 SHALL let start in the same cycle done rises begin a new decode on the next edge after DONE is entered.

Reset
REQ-025 SHALL, on rst=1 and independently of clk, force state=IDLE, busy=0, done=0, dec_out=0, all metrics=0 and the step counter=0.
REQ-026 SHALL abort any decode when rst is asserted mid-ACS or mid-TB, with no partial dec_out update.
REQ-027 SHALL, after rst falls, accept the first start on the next posedge.

Configuration
REQ-028 SHALL, with VITERBI_ERRCNT_EN defined, add output port err_cnt [MW-1:0], equal to the final best-path metric (corrected channel bit errors), updated with dec_out and reset to 0.
REQ-029 SHALL, with VITERBI_ERRCNT_EN undefined, have no err_cnt port and no logic to capture it; all other behaviour is identical.

Verification
REQ-030 SHALL cover: in_code = 0, start -> at edge 97: dec_out = 48'h0, done=1, busy=0, err_cnt=0.
REQ-031 SHALL cover: in_code[95:88] = 8'hDF, rest 0 (u[0]=1 only) -> dec_out = 48'h800000000000, err_cnt=0.
REQ-032 SHALL cover: the previous vector with bit 95 flipped (8'h5F) -> dec_out = 48'h800000000000, err_cnt=1.
REQ-033 SHALL cover: u = 48'hA5A5_C3C3_0F0F, encoded by the bench model, with bits 80 and 40 flipped -> dec_out = 48'hA5A5_C3C3_0F0F, err_cnt=2.
REQ-034 SHALL cover: a second start with different in_code at edge 30 of a decode -> ignored; done at edge 97 with the first block's result.
REQ-035 SHALL cover: rst pulsed at edge 60 of a decode -> busy=0, done=0, dec_out=0 immediately; a fresh start decodes correctly.
